// File: rtl/alu_issue.sv
// alu_issue: single-outstanding issue stage between a request port and an ALU.
//   clk, reset_n             : clock, asynchronous active-low reset
//   req_valid/req_ready      : request handshake, req_opcode/req_a/req_b operands
//   rsp_valid/rsp_ready      : response handshake, rsp_result/rsp_overflow/rsp_error/rsp_timeout
//   alu_a/alu_b/alu_opcode   : operand registers driven to the ALU, alu_enable high in EXEC
//   alu_result/alu_overflow/alu_error/alu_done : ALU outputs, sampled only in EXEC
//   busy                     : not IDLE
//   sticky_ovf/sticky_err    : accumulated flags, cleared by clr_sticky
//   op_count                 : completed response handshakes, wraps at 16 bits
module alu_issue #(
    parameter int unsigned TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_opcode,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_overflow,
    output logic        rsp_error,
    output logic        rsp_timeout,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_opcode,
    output logic        alu_enable,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    input  logic        alu_error,
    input  logic        alu_done,
    output logic        busy,
    output logic        sticky_ovf,
    output logic        sticky_err,
    input  logic        clr_sticky,
    output logic [15:0] op_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [4:0]  opc_q;
    logic [31:0] a_q, b_q;
    logic [31:0] res_q, res_d;
    logic        ovf_q, ovf_d, err_q, err_d, tmo_q, tmo_d;
    logic        sovf_q, sovf_d, serr_q, serr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ready_q;
    logic        accept, complete, expire, capture, handshake;

    // ready_q keeps req_ready low until the first edge after reset release
    assign req_ready    = ready_q && state_q == IDLE;
    assign rsp_valid    = state_q == RESP;
    assign alu_enable   = state_q == EXEC;
    assign busy         = state_q != IDLE;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_opcode   = opc_q;
    assign rsp_result   = res_q;
    assign rsp_overflow = ovf_q;
    assign rsp_error    = err_q;
    assign rsp_timeout  = tmo_q;
    assign sticky_ovf   = sovf_q;
    assign sticky_err   = serr_q;
    assign op_count     = cnt_q;

    always_comb begin
        accept    = req_valid && req_ready;
        complete  = state_q == EXEC && (alu_done || alu_error);
        // completion on the last wait cycle takes priority over the timeout
        expire    = state_q == EXEC && !complete && wait_q == WAIT_LAST;
        capture   = complete || expire;
        handshake = state_q == RESP && rsp_ready;
        state_d   = accept ? EXEC : capture ? RESP : handshake ? IDLE : state_q;
        wait_d    = state_q == EXEC ? wait_q + 8'd1 : 8'd0;
        res_d     = capture ? (complete ? alu_result : 32'd0) : res_q;
        ovf_d     = capture ? complete && alu_overflow : ovf_q;
        err_d     = capture ? expire || alu_error : err_q;
        tmo_d     = capture ? expire : tmo_q;
        // a flag arriving on the same edge as clr_sticky survives the clear
        sovf_d    = (capture && complete && alu_overflow) || (sovf_q && !clr_sticky);
        serr_d    = (capture && (expire || alu_error)) || (serr_q && !clr_sticky);
        cnt_d     = handshake ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wait_q  <= 8'd0;
            opc_q   <= 5'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            res_q   <= 32'd0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            sovf_q  <= 1'b0;
            serr_q  <= 1'b0;
            cnt_q   <= 16'd0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (accept) begin
                opc_q <= req_opcode;
                a_q   <= req_a;
                b_q   <= req_b;
            end
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            sovf_q  <= sovf_d;
            serr_q  <= serr_d;
            cnt_q   <= cnt_d;
            ready_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: vector table, hand sequences and random ops against a transaction-level model.
module tb_alu_issue;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready;
    logic [4:0]  req_opcode;
    logic [31:0] req_a, req_b;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_overflow, rsp_error, rsp_timeout;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_opcode;
    logic        alu_enable;
    logic [31:0] alu_result;
    logic        alu_overflow, alu_error, alu_done;
    logic        busy, sticky_ovf, sticky_err, clr_sticky;
    logic [15:0] op_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_cnt;
    bit          m_sovf, m_serr;

    alu_issue #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_enable(alu_enable),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_error(alu_error),
        .alu_done(alu_done), .busy(busy), .sticky_ovf(sticky_ovf), .sticky_err(sticky_err),
        .clr_sticky(clr_sticky), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // opcodes: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, anything else undefined
    function automatic void ref_alu(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output bit ovf, output bit def);
        longint sa, sb, s;
        longint unsigned p;
        sa = $signed(a);
        sb = $signed(b);
        r = 32'd0; ovf = 1'b0; def = 1'b1;
        case (opc)
            5'd0: begin s = sa + sb; r = 32'(s); ovf = s > 64'sd2147483647 || s < -64'sd2147483648; end
            5'd1: begin s = sa - sb; r = 32'(s); ovf = s > 64'sd2147483647 || s < -64'sd2147483648; end
            5'd2: begin p = 64'(a) * 64'(b); r = 32'(p); ovf = (p >> 32) != 0; end
            5'd3: r = a & b;
            5'd4: r = a | b;
            5'd5: r = a ^ b;
            default: def = 1'b0;
        endcase
    endfunction

    // Bench ALU: answers alu_lat cycles into EXEC; drives garbage whenever not enabled.
    int          alu_lat = 0;
    int          ecnt = 0;
    logic [31:0] b_r;
    bit          b_o, b_d, fire;
    always @(posedge clk) ecnt <= alu_enable ? ecnt + 1 : 0;
    always_comb begin
        ref_alu(alu_opcode, alu_a, alu_b, b_r, b_o, b_d);
        fire         = alu_enable && ecnt >= alu_lat;
        alu_result   = alu_enable ? (fire ? b_r : 32'hBAD0BAD0) : 32'hDEADBEEF;
        alu_overflow = alu_enable ? fire && b_o : 1'b1;
        alu_done     = alu_enable ? fire && b_d : 1'b1;
        alu_error    = alu_enable ? fire && !b_d : 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic run_op(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int hold, input bit clr_in,
                          input logic [31:0] e_res, input bit e_ovf, input bit e_err,
                          input bit e_tmo, input int e_cyc);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_opcode = opc; req_a = a; req_b = b;
        alu_lat = lat; rsp_ready = 1'b0; clr_sticky = clr_in;
        n = 0;
        while (!req_ready && n < 10) begin @(negedge clk); n++; end
        chk("accept_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0; req_opcode = 5'($urandom); req_a = $urandom; req_b = $urandom;
        chk("alu_a", alu_a, a);
        chk("alu_opcode", alu_opcode, opc);
        n = 0;
        while (alu_enable && n < 300) begin @(negedge clk); n++; end
        if (clr_in) begin m_sovf = 0; m_serr = 0; end
        m_sovf = m_sovf | e_ovf;
        m_serr = m_serr | e_err | e_tmo;
        chk("enable_cycles", n, e_cyc);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_result", rsp_result, e_res);
        chk("rsp_overflow", rsp_overflow, e_ovf);
        chk("rsp_error", rsp_error, e_err);
        chk("rsp_timeout", rsp_timeout, e_tmo);
        chk("sticky_ovf", sticky_ovf, m_sovf);
        chk("sticky_err", sticky_err, m_serr);
        clr_sticky = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_result", rsp_result, e_res);
            chk("hold_ready", req_ready, 0);
            chk("hold_busy", busy, 1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        m_cnt = m_cnt + 16'd1;
        chk("post_valid", rsp_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_ready", req_ready, 1);
        chk("op_count", op_count, m_cnt);
        chk("retain_result", rsp_result, e_res);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        m_sovf = 0; m_serr = 0;
        chk("clr_sovf", sticky_ovf, 0);
        chk("clr_serr", sticky_err, 0);
    endtask

    typedef struct {
        logic [4:0]  opc;
        logic [31:0] a, b;
        int          lat, hold;
        logic [31:0] res;
        bit          ovf, err, tmo;
        int          cyc;
    } vec_t;

    vec_t        vt[13];
    logic [31:0] corner[5];

    function automatic logic [31:0] pick();
        return $urandom_range(0, 2) == 0 ? corner[$urandom_range(0, 4)] : $urandom;
    endfunction

    initial begin
        logic [31:0] r;
        bit o, d;
        int lat, seen;
        logic [4:0] opc;
        logic [31:0] a, b;

        vt[0]  = '{5'd0, 32'd5,          32'd1,          0,   0, 32'd6,          0, 0, 0, 1};
        vt[1]  = '{5'd0, 32'h7FFFFFFF,   32'd1,          0,   0, 32'h80000000,   1, 0, 0, 1};
        vt[2]  = '{5'd2, 32'd3,          32'd4,          1,   5, 32'd12,         0, 0, 0, 2};
        vt[3]  = '{5'd1, 32'd0,          32'd1,          0,   1, 32'hFFFFFFFF,   0, 0, 0, 1};
        vt[4]  = '{5'd1, 32'h80000000,   32'd1,          2,   0, 32'h7FFFFFFF,   1, 0, 0, 3};
        vt[5]  = '{5'd5, 32'hF0F0F0F0,   32'hFF00FF00,   0,   0, 32'h0FF00FF0,   0, 0, 0, 1};
        vt[6]  = '{5'd31, 32'd9,         32'd9,          0,   0, 32'd0,          0, 1, 0, 1};
        vt[7]  = '{5'd0, 32'd1,          32'd1,          3,   0, 32'd2,          0, 0, 0, 4};
        vt[8]  = '{5'd0, 32'd1,          32'd1,          4,   0, 32'd0,          0, 1, 1, 4};
        vt[9]  = '{5'd3, 32'hFFFF0000,   32'h12345678,   0,   0, 32'h12340000,   0, 0, 0, 1};
        vt[10] = '{5'd4, 32'h0000000F,   32'h000000F0,   0,   2, 32'h000000FF,   0, 0, 0, 1};
        vt[11] = '{5'd2, 32'h00010000,   32'h00010000,   0,   0, 32'd0,          1, 0, 0, 1};
        vt[12] = '{5'd2, 32'd3,          32'd4,          255, 0, 32'd0,          0, 1, 1, 4};
        corner = '{32'd0, 32'd1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

        reset_n = 1'b0; req_valid = 1'b0; req_opcode = 5'd0; req_a = 32'd0; req_b = 32'd0;
        rsp_ready = 1'b0; clr_sticky = 1'b0;
        m_cnt = 16'd0; m_sovf = 0; m_serr = 0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_enable", alu_enable, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_sticky", {sticky_ovf, sticky_err}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", req_ready, 1);

        foreach (vt[i]) begin
            run_op(vt[i].opc, vt[i].a, vt[i].b, vt[i].lat, vt[i].hold, 1'b0,
                   vt[i].res, vt[i].ovf, vt[i].err, vt[i].tmo, vt[i].cyc);
            if (i == 1) pulse_clr();
        end

        // flag captured while clr_sticky is held: the new flag survives
        run_op(5'd0, 32'h7FFFFFFF, 32'd1, 0, 0, 1'b1, 32'h80000000, 1, 0, 0, 1);
        pulse_clr();

        // reset in the middle of a stalled EXEC
        @(negedge clk);
        req_valid = 1'b1; req_opcode = 5'd0; req_a = 32'd1; req_b = 32'd2; alu_lat = 255;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_enable", alu_enable, 1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_enable", alu_enable, 0);
        chk("async_busy", busy, 0);
        chk("async_ready", req_ready, 0);
        chk("async_valid", rsp_valid, 0);
        chk("async_count", op_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        m_cnt = 16'd0; m_sovf = 0; m_serr = 0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid || alu_enable) seen++;
        end
        chk("no_rsp_after_reset", seen, 0);
        chk("rel2_ready", req_ready, 1);
        chk("rel2_count", op_count, 0);

        for (int i = 0; i < 150; i++) begin
            opc = 5'($urandom_range(0, 7));
            a = pick();
            b = pick();
            lat = $urandom_range(0, 6);
            ref_alu(opc, a, b, r, o, d);
            if (lat <= TIMEOUT - 1)
                run_op(opc, a, b, lat, $urandom_range(0, 2), 1'($urandom_range(0, 1)), r, o, !d, 0, lat + 1);
            else
                run_op(opc, a, b, lat, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 32'd0, 0, 1, 1, TIMEOUT);
            if ($urandom_range(0, 9) == 0) pulse_clr();
        end

        // preset the counter near the top instead of running 65536 handshakes
        @(negedge clk);
        force dut.cnt_q = 16'hFFFE;
        #1 release dut.cnt_q;
        m_cnt = 16'hFFFE;
        chk("preset_count", op_count, 16'hFFFE);
        run_op(5'd0, 32'd2, 32'd3, 0, 0, 1'b0, 32'd5, 0, 0, 0, 1);
        run_op(5'd4, 32'd8, 32'd1, 1, 0, 1'b0, 32'd9, 0, 0, 0, 2);
        chk("wrap_count", op_count, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
